// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the control unit and the M-extension unit.
// The issuing side drives the i_* signals, the unit drives the o_* signals.
interface muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             i_valid;
    logic             o_ready;
    logic [2:0]       i_funct3;
    logic [XLEN-1:0]  i_operand_a;
    logic [XLEN-1:0]  i_operand_b;
    logic [TAG_W-1:0] i_rd_addr;
    logic             i_flush;
    logic             o_valid;
    logic [XLEN-1:0]  o_result;
    logic [TAG_W-1:0] o_rd_addr;

    modport master (
        output i_valid, i_funct3, i_operand_a, i_operand_b, i_rd_addr, i_flush,
        input  o_ready, o_valid, o_result, o_rd_addr
    );

    modport slave (
        input  i_valid, i_funct3, i_operand_a, i_operand_b, i_rd_addr, i_flush,
        output o_ready, o_valid, o_result, o_rd_addr
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// magnitudes in the core loop and a final sign fix before the result is shown.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [XLEN-1:0]  opnd, acc, lo;
    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic             neg_q, neg_r;
    logic [XLEN-1:0]  res_q;
    logic [TAG_W-1:0] rd_q;

    logic             accept, last_iter;
    logic             sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic             div_zero, special;
    logic [XLEN-1:0]  spec_res;
    logic [XLEN:0]    mul_sum, div_sh, div_tr;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix, rem_fix, fix_res;

    assign bus.o_ready   = (state == IDLE);
    assign bus.o_valid   = (state == DONE);
    assign bus.o_result  = res_q;
    assign bus.o_rd_addr = rd_q;

    assign accept    = bus.i_valid && (state == IDLE) && !bus.i_flush;
    assign last_iter = (cnt == CW'(XLEN - 1));

    // Operand decode at accept: signedness, magnitudes and the special cases.
    always_comb begin
        sgn_a    = bus.i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        sgn_b    = bus.i_funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        neg_a    = sgn_a && bus.i_operand_a[XLEN-1];
        neg_b    = sgn_b && bus.i_operand_b[XLEN-1];
        mag_a    = neg_a ? -bus.i_operand_a : bus.i_operand_a;
        mag_b    = neg_b ? -bus.i_operand_b : bus.i_operand_b;
        div_zero = (bus.i_operand_b == '0);
        special  = bus.i_funct3[2] && (div_zero ||
                   (!bus.i_funct3[0] && bus.i_operand_a == MIN_VAL &&
                    bus.i_operand_b == '1));
        if (div_zero)
            spec_res = bus.i_funct3[1] ? bus.i_operand_a : '1;
        else
            spec_res = bus.i_funct3[1] ? '0 : bus.i_operand_a;
    end

    // One loop step and the sign fix-up of the finished magnitudes.
    always_comb begin
        mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc, lo[XLEN-1]};
        div_tr   = div_sh - {1'b0, opnd};
        prod_fix = neg_q ? -{acc, lo} : {acc, lo};
        quo_fix  = neg_q ? -lo : lo;
        rem_fix  = neg_r ? -acc : acc;
        if (!op[2])
            fix_res = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                         : prod_fix[2*XLEN-1:XLEN];
        else
            fix_res = op[1] ? rem_fix : quo_fix;
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; a flush wins over everything else.
    always_comb begin
        state_nxt = state;
        if (bus.i_flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_nxt = special ? DONE : CALC;
                CALC: if (last_iter) state_nxt = FIX;
                FIX:  state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            opnd  <= '0;
            acc   <= '0;
            lo    <= '0;
            cnt   <= '0;
            op    <= '0;
            tag   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            res_q <= '0;
            rd_q  <= '0;
        end else if (accept) begin
            op    <= bus.i_funct3;
            tag   <= bus.i_rd_addr;
            cnt   <= '0;
            acc   <= '0;
            neg_q <= neg_a ^ neg_b;
            neg_r <= neg_a;
            opnd  <= bus.i_funct3[2] ? mag_b : mag_a;
            lo    <= bus.i_funct3[2] ? mag_a : mag_b;
            if (special) begin
                res_q <= spec_res;
                rd_q  <= bus.i_rd_addr;
            end
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            if (!op[2]) begin
                acc <= mul_sum[XLEN:1];
                lo  <= {mul_sum[0], lo[XLEN-1:1]};
            end else begin
                acc <= div_tr[XLEN] ? div_sh[XLEN-1:0] : div_tr[XLEN-1:0];
                lo  <= {lo[XLEN-2:0], ~div_tr[XLEN]};
            end
        end else if (state == FIX && !bus.i_flush) begin
            res_q <= fix_res;
            rd_q  <= tag;
        end
    end
endmodule
